multi_cycle_control: RTL and testbench
======================================

# multi_cycle_control

Moore-style control unit for the multi-cycle CPU. Sequences each instruction through fetch/decode/execute/memory/write-back states and drives every datapath and memory control strobe. These include MemRead, MemWrite and IorD for the shared instruction/data memory, IRWrite for the instruction register, and the PC, register-file and ALU selects. It sits directly upstream of the unified memory and consumes OpCode/Funct from the instruction register that memory loads.

## Interface
- No parameters; state encoding fixed as below.
- reset  in  1  asynchronous, active-high; forces state to FETCH
- clk  in  1  system clock, rising edge
- OpCode  in  6  instruction[31:26] from IR
- Funct  in  6  instruction[5:0] from IR
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load gated by ALU Zero (beq)
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read enable
- MemWrite  out  1  memory write enable
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  register write data: 0 = ALUOut, 1 = MDR
- RegDst  out  1  write register: 0 = rt, 1 = rd
- RegWrite  out  1  register file write enable
- ExtOp  out  1  1 = sign-extend imm16, 0 = zero-extend
- LuOp  out  1  1 = imm16 shifted to upper half (lui)
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = ext imm, 11 = ext imm << 2
- ALUOp  out  2  00 add, 01 sub, 10 R-type (ALU control decodes Funct), 11 I-type (ALU control decodes OpCode)
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- State  out  4  current state, for debug/verification

## Operation
- 4-bit state register, async reset to FETCH (0). All outputs are combinational decodes of state, plus OpCode for ExtOp/LuOp.
- Unlisted outputs are 0 in each state.
- While reset is high every output is forced to 0, State reads 0.
- S0 FETCH:
  - Drives MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, PCWrite=1.
  - Next state is S1.
- S1 DECODE:
  - Drives ALUSrcA=0, ALUSrcB=11, ALUOp=00, ExtOp=1 (branch target into ALUOut).
  - Next state by OpCode:
    - 0x23 lw or 0x2b sw -> S2
    - 0x00 R-type -> S6
    - 0x04 beq -> S8
    - 0x02 j -> S9
    - 0x08/0x09/0x0a/0x0b/0x0c/0x0d/0x0f -> S10
    - any other opcode -> S0 (instruction ignored, no writes)
- S2 MEMADDR:
  - Drives ALUSrcA=1, ALUSrcB=10, ALUOp=00, ExtOp=1.
  - lw -> S3; sw -> S5.
- S3 MEMRD: MemRead=1, IorD=1 -> S4.
- S4 LDWB: RegDst=0, MemtoReg=1, RegWrite=1 -> S0.
- S5 MEMWR: MemWrite=1, IorD=1 -> S0.
- S6 REXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> S7. Includes setsub (Funct 0x28), add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2a.
- S7 RWB: RegDst=1, MemtoReg=0, RegWrite=1 -> S0.
- S8 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> S0.
- S9 JUMP: PCWrite=1, PCSource=10 -> S0.
- S10 IEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=11 -> S11.
  - ExtOp=0 for 0x0c/0x0d, else 1.
  - LuOp=1 only for 0x0f.
- S11 IWB: RegDst=0, MemtoReg=0, RegWrite=1 -> S0.
- Codes 12-15 unused; if reached, next state is S0 with all outputs 0.
- MemRead and MemWrite are never both 1. IRWrite is asserted only in FETCH.

## Timing
- State advances on every rising clk. There are no stalls and no handshake; memory is single-cycle.
- OpCode/Funct are valid from S1 onward, since IR loads at the end of FETCH.
- Cycles per instruction:
  - lw 5
  - sw, R-type, I-type 4
  - beq, j 3
  - illegal 2
- Reset asserted mid-instruction: state and outputs go to 0 immediately, with no clock edge needed. Any pending RegWrite/MemWrite is dropped.
- The first rising clk after reset deassertion executes FETCH; State=1 after that edge.

## Test plan
- Reset then OpCode=0x0f (lui): State sequence 0,1,10,11,0. LuOp=1 in S10; RegWrite=1, RegDst=0 in S11.
- OpCode=0x00, Funct=0x28 (setsub): State sequence 0,1,6,7. ALUOp=10 in S6; RegDst=1, RegWrite=1 in S7; 4 cycles total.
- OpCode=0x04 (beq): State sequence 0,1,8,0. PCWriteCond=1, PCSource=01, ALUOp=01 in S8; no RegWrite at any point.
- OpCode=0x23 then 0x2b: lw visits 0,1,2,3,4 with IorD=1, MemRead=1 in S3 and MemtoReg=1 in S4. sw visits 0,1,2,5 with MemWrite=1 only in S5.
- OpCode=0x0c (andi) -> ExtOp=0 in S10. OpCode=0x3f (illegal) -> 0,1,0 with no writes.
- Assert reset while in S5 with MemWrite=1: MemWrite drops to 0 in the same cycle, State=0. After release, the next edge gives State=1.

Source files
------------

// File: rtl/multi_cycle_control_if.sv
// Control-strobe bundle between the multi-cycle control unit and its datapath.
// master = control unit (consumes IR fields, drives strobes); slave = datapath side.
interface multi_cycle_control_if;
  logic [5:0] OpCode;
  logic [5:0] Funct;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ExtOp;
  logic       LuOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic [3:0] State;

  modport master (
    input  OpCode, Funct,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ExtOp, LuOp, ALUSrcA,
           ALUSrcB, ALUOp, PCSource, State
  );

  modport slave (
    output OpCode, Funct,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ExtOp, LuOp, ALUSrcA,
           ALUSrcB, ALUOp, PCSource, State
  );
endinterface

// File: rtl/multi_cycle_control.sv
// Moore control unit for the multi-cycle CPU: sequences fetch/decode/execute/memory/
// write-back and decodes every datapath and memory strobe from the current state.
module multi_cycle_control (
  input  logic                         clk,
  input  logic                         reset,
  multi_cycle_control_if.master        bus
);
  localparam int unsigned SW = 4;

  typedef enum logic [SW-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_LDWB    = 4'd4,
    S_MEMWR   = 4'd5,
    S_REXEC   = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_IEXEC   = 4'd10,
    S_IWB     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  state_t     r_state;
  state_t     w_next;
  logic       w_pcwrite, w_pcwritecond, w_iord, w_memread, w_memwrite, w_irwrite;
  logic       w_memtoreg, w_regdst, w_regwrite, w_extop, w_luop, w_alusrca;
  logic [1:0] w_alusrcb, w_aluop, w_pcsource;

  // State register; reset returns to FETCH without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next        = S_FETCH;
    w_pcwrite     = 1'b0;
    w_pcwritecond = 1'b0;
    w_iord        = 1'b0;
    w_memread     = 1'b0;
    w_memwrite    = 1'b0;
    w_irwrite     = 1'b0;
    w_memtoreg    = 1'b0;
    w_regdst      = 1'b0;
    w_regwrite    = 1'b0;
    w_extop       = 1'b0;
    w_luop        = 1'b0;
    w_alusrca     = 1'b0;
    w_alusrcb     = 2'b00;
    w_aluop       = 2'b00;
    w_pcsource    = 2'b00;

    case (r_state)
      S_FETCH: begin
        w_memread = 1'b1;
        w_irwrite = 1'b1;
        w_alusrcb = 2'b01;
        w_pcwrite = 1'b1;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        w_alusrcb = 2'b11;
        w_extop   = 1'b1;
        case (bus.OpCode)
          OP_LW, OP_SW:                   w_next = S_MEMADDR;
          OP_RTYPE:                       w_next = S_REXEC;
          OP_BEQ:                         w_next = S_BRANCH;
          OP_J:                           w_next = S_JUMP;
          OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
          OP_ANDI, OP_ORI, OP_LUI:        w_next = S_IEXEC;
          default:                        w_next = S_FETCH;
        endcase
      end
      S_MEMADDR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_extop   = 1'b1;
        w_next    = (bus.OpCode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_memread = 1'b1;
        w_iord    = 1'b1;
        w_next    = S_LDWB;
      end
      S_LDWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
      end
      S_MEMWR: begin
        w_memwrite = 1'b1;
        w_iord     = 1'b1;
      end
      S_REXEC: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b10;
        w_next    = S_RWB;
      end
      S_RWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BRANCH: begin
        w_alusrca     = 1'b1;
        w_aluop       = 2'b01;
        w_pcwritecond = 1'b1;
        w_pcsource    = 2'b01;
      end
      S_JUMP: begin
        w_pcwrite  = 1'b1;
        w_pcsource = 2'b10;
      end
      S_IEXEC: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_aluop   = 2'b11;
        w_extop   = !((bus.OpCode == OP_ANDI) || (bus.OpCode == OP_ORI));
        w_luop    = (bus.OpCode == OP_LUI);
        w_next    = S_IWB;
      end
      S_IWB: begin
        w_regwrite = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase

    // Reset silences every strobe so no write can slip through mid-instruction.
    if (reset) begin
      w_pcwrite     = 1'b0;
      w_pcwritecond = 1'b0;
      w_iord        = 1'b0;
      w_memread     = 1'b0;
      w_memwrite    = 1'b0;
      w_irwrite     = 1'b0;
      w_memtoreg    = 1'b0;
      w_regdst      = 1'b0;
      w_regwrite    = 1'b0;
      w_extop       = 1'b0;
      w_luop        = 1'b0;
      w_alusrca     = 1'b0;
      w_alusrcb     = 2'b00;
      w_aluop       = 2'b00;
      w_pcsource    = 2'b00;
    end
  end

  assign bus.PCWrite     = w_pcwrite;
  assign bus.PCWriteCond = w_pcwritecond;
  assign bus.IorD        = w_iord;
  assign bus.MemRead     = w_memread;
  assign bus.MemWrite    = w_memwrite;
  assign bus.IRWrite     = w_irwrite;
  assign bus.MemtoReg    = w_memtoreg;
  assign bus.RegDst      = w_regdst;
  assign bus.RegWrite    = w_regwrite;
  assign bus.ExtOp       = w_extop;
  assign bus.LuOp        = w_luop;
  assign bus.ALUSrcA     = w_alusrca;
  assign bus.ALUSrcB     = w_alusrcb;
  assign bus.ALUOp       = w_aluop;
  assign bus.PCSource    = w_pcsource;
  assign bus.State       = reset ? 4'd0 : SW'(r_state);
endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: path-based reference model checked every cycle,
// plus directed instruction runs with hand-computed state traces and strobe values.
module tb_multi_cycle_control;
  typedef struct packed {
    logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, ext, lu, srca;
    logic [1:0] srcb, aluop, pcsrc;
  } ctl_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_state  = 0;
  ctl_t w_dut;
  ctl_t snap [16];

  multi_cycle_control_if bus ();

  multi_cycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign w_dut = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                  bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ExtOp,
                  bus.LuOp, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource};

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: each opcode class walks a fixed list of states, then returns to FETCH.
  function automatic int next_state(input int s, input logic [5:0] op);
    int p[$];
    if (s == 0) return 1;
    case (op)
      6'h23:                                    p = '{0, 1, 2, 3, 4};
      6'h2b:                                    p = '{0, 1, 2, 5};
      6'h00:                                    p = '{0, 1, 6, 7};
      6'h04:                                    p = '{0, 1, 8};
      6'h02:                                    p = '{0, 1, 9};
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0f: p = '{0, 1, 10, 11};
      default:                                  p = '{0, 1};
    endcase
    for (int i = 0; i + 1 < p.size(); i++)
      if (p[i] == s) return p[i+1];
    return 0;
  endfunction

  function automatic ctl_t model_out(input int s, input logic [5:0] op);
    ctl_t c;
    c = '0;
    case (s)
      0:  begin c.mrd = 1'b1; c.irw = 1'b1; c.srcb = 2'b01; c.pcw = 1'b1; end
      1:  begin c.srcb = 2'b11; c.ext = 1'b1; end
      2:  begin c.srca = 1'b1; c.srcb = 2'b10; c.ext = 1'b1; end
      3:  begin c.mrd = 1'b1; c.iord = 1'b1; end
      4:  begin c.m2r = 1'b1; c.rw = 1'b1; end
      5:  begin c.mwr = 1'b1; c.iord = 1'b1; end
      6:  begin c.srca = 1'b1; c.aluop = 2'b10; end
      7:  begin c.rdst = 1'b1; c.rw = 1'b1; end
      8:  begin c.srca = 1'b1; c.aluop = 2'b01; c.pcwc = 1'b1; c.pcsrc = 2'b01; end
      9:  begin c.pcw = 1'b1; c.pcsrc = 2'b10; end
      10: begin
        c.srca = 1'b1; c.srcb = 2'b10; c.aluop = 2'b11;
        c.ext  = !(op == 6'h0c || op == 6'h0d);
        c.lu   = (op == 6'h0f);
      end
      11: c.rw = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m_state <= 0;
    else       m_state <= next_state(m_state, bus.OpCode);
  end

  // Every falling edge: DUT strobes and state against the reference.
  always @(negedge clk) begin
    check("cyc_ctl",   int'(w_dut),     reset ? 0 : int'(model_out(m_state, bus.OpCode)));
    check("cyc_state", int'(bus.State), reset ? 0 : m_state);
  end

  int          tr_idx, n_rw, n_mw;
  logic [31:0] tr_seq;

  task automatic sample();
    if (tr_idx < 8) tr_seq[4*tr_idx +: 4] = bus.State;
    tr_idx++;
    snap[bus.State] = w_dut;
    n_rw += int'(bus.RegWrite);
    n_mw += int'(bus.MemWrite);
  endtask

  // Issue one instruction from FETCH; trace states until FETCH comes round again.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic [31:0] exp_seq, input int exp_cyc);
    int cyc;
    #1;
    bus.OpCode = op;
    bus.Funct  = fn;
    for (int i = 0; i < 16; i++) snap[i] = '0;
    tr_seq = '0; tr_idx = 0; n_rw = 0; n_mw = 0; cyc = 0;
    sample();
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (bus.State == 4'd0) break;
      sample();
    end
    check({name, "_seq"},    int'(tr_seq), int'(exp_seq));
    check({name, "_cycles"}, cyc,          exp_cyc);
  endtask

  initial begin
    bus.OpCode = 6'h00;
    bus.Funct  = 6'h00;
    repeat (2) @(negedge clk);
    check("rst_state", int'(bus.State), 0);
    check("rst_ctl",   int'(w_dut),     0);
    #1 reset = 1'b0;

    run_instr("lui", 6'h0f, 6'h00, 32'h0000_BA10, 4);
    check("lui_LuOp_S10",    int'(snap[10].lu),   1);
    check("lui_RegWrite_S11", int'(snap[11].rw),  1);
    check("lui_RegDst_S11",  int'(snap[11].rdst), 0);
    check("fetch_IRWrite",   int'(snap[0].irw),   1);
    check("fetch_MemRead",   int'(snap[0].mrd),   1);

    run_instr("setsub", 6'h00, 6'h28, 32'h0000_7610, 4);
    check("setsub_ALUOp_S6", int'(snap[6].aluop), 2);
    check("setsub_RegDst_S7", int'(snap[7].rdst), 1);
    check("setsub_RegWrite_S7", int'(snap[7].rw), 1);

    run_instr("beq", 6'h04, 6'h00, 32'h0000_0810, 3);
    check("beq_PCWriteCond", int'(snap[8].pcwc),  1);
    check("beq_PCSource",    int'(snap[8].pcsrc), 1);
    check("beq_ALUOp",       int'(snap[8].aluop), 1);
    check("beq_no_RegWrite", n_rw,                0);

    run_instr("lw", 6'h23, 6'h00, 32'h0004_3210, 5);
    check("lw_IorD_S3",     int'(snap[3].iord), 1);
    check("lw_MemRead_S3",  int'(snap[3].mrd),  1);
    check("lw_MemtoReg_S4", int'(snap[4].m2r),  1);

    run_instr("sw", 6'h2b, 6'h00, 32'h0000_5210, 4);
    check("sw_MemWrite_S5",    int'(snap[5].mwr), 1);
    check("sw_MemWrite_count", n_mw,              1);

    run_instr("andi", 6'h0c, 6'h00, 32'h0000_BA10, 4);
    check("andi_ExtOp_S10", int'(snap[10].ext), 0);

    run_instr("addi", 6'h08, 6'h00, 32'h0000_BA10, 4);
    check("addi_ExtOp_S10", int'(snap[10].ext), 1);

    run_instr("illegal", 6'h3f, 6'h00, 32'h0000_0010, 2);
    check("illegal_no_writes", n_rw + n_mw, 0);

    run_instr("j", 6'h02, 6'h00, 32'h0000_0910, 3);
    check("j_PCSource", int'(snap[9].pcsrc), 2);

    // Reset dropped on a store in MEMWR must kill MemWrite without a clock edge.
    #1 bus.OpCode = 6'h2b;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.State == 4'd5) break;
    end
    check("mw_before_rst_state", int'(bus.State),    5);
    check("mw_before_rst",       int'(bus.MemWrite), 1);
    #1 reset = 1'b1;
    #1;
    check("mw_during_rst",    int'(bus.MemWrite), 0);
    check("state_during_rst", int'(bus.State),    0);
    @(negedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    check("state_after_release", int'(bus.State), 1);
    repeat (6) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end
endmodule
